downcount_event_monitor: RTL

Event monitor that sits directly downstream of the 32-bit down counter and consumes its count value every clock. It detects a programmable compare match, the 0 -> 0xFFFFFFFF underflow wrap, and reloads (count jumping upward, e.g. reset to 0x7FFFFFFF). It raises one-cycle event pulses, sticky status bits, a masked interrupt and a saturating match counter. A simple single-cycle write port configures it.

---
 rtl/downcount_event_monitor.sv | 105 ++++++++++
 1 files changed

// File: rtl/downcount_event_monitor.sv
// Event monitor downstream of a 32-bit down counter: compare-match, underflow wrap
// and reload detection with pulses, sticky status, masked irq and a saturating match count.
module downcount_event_monitor #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] count_in,
    input  logic             count_valid,
    input  logic             cfg_we,
    input  logic [1:0]       cfg_addr,
    input  logic [WIDTH-1:0] cfg_wdata,
    output logic             match_pulse,
    output logic             wrap_pulse,
    output logic             reload_pulse,
    output logic [2:0]       status,
    output logic             irq,
    output logic [CNT_W-1:0] match_cnt
);

    logic [WIDTH-1:0] cmp_q, cmp_d;
    logic [WIDTH-1:0] prev_count_q, prev_count_d;
    logic             prev_valid_q, prev_valid_d;
    logic [2:0]       irq_en_q, irq_en_d;
    logic [2:0]       status_q, status_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             match_q, wrap_q, reload_q, irq_q;

    logic             ev_match, ev_wrap, ev_reload;
    logic [2:0]       status_clr;
    logic             cnt_clr;

    // Match is edge-qualified so a counter parked on cmp_val fires only once.
    always_comb begin
        ev_match  = count_valid && (count_in == cmp_q) &&
                    (!prev_valid_q || (prev_count_q != cmp_q));
        ev_wrap   = count_valid && prev_valid_q &&
                    (prev_count_q == '0) && (count_in == '1);
        ev_reload = count_valid && prev_valid_q &&
                    (count_in > prev_count_q) && !ev_wrap;
    end

    always_comb begin
        cmp_d        = cmp_q;
        irq_en_d     = irq_en_q;
        status_clr   = '0;
        cnt_clr      = 1'b0;
        prev_count_d = prev_count_q;
        prev_valid_d = prev_valid_q;
        if (cfg_we) begin
            case (cfg_addr)
                2'd0:    cmp_d      = cfg_wdata;
                2'd1:    irq_en_d   = cfg_wdata[2:0];
                2'd2:    status_clr = cfg_wdata[2:0];
                default: cnt_clr    = 1'b1;
            endcase
        end
        if (count_valid) begin
            prev_count_d = count_in;
            prev_valid_d = 1'b1;
        end
        // Set has priority over a same-cycle write-1-to-clear.
        status_d = (status_q & ~status_clr) | {ev_reload, ev_wrap, ev_match};
        cnt_d    = cnt_q;
        if (cnt_clr)
            cnt_d = ev_match ? CNT_W'(1) : '0;
        else if (ev_match && (cnt_q != '1))
            cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cmp_q        <= '0;
            irq_en_q     <= '0;
            prev_count_q <= '0;
            prev_valid_q <= 1'b0;
            status_q     <= '0;
            cnt_q        <= '0;
            match_q      <= 1'b0;
            wrap_q       <= 1'b0;
            reload_q     <= 1'b0;
            irq_q        <= 1'b0;
        end else begin
            cmp_q        <= cmp_d;
            irq_en_q     <= irq_en_d;
            prev_count_q <= prev_count_d;
            prev_valid_q <= prev_valid_d;
            status_q     <= status_d;
            cnt_q        <= cnt_d;
            match_q      <= ev_match;
            wrap_q       <= ev_wrap;
            reload_q     <= ev_reload;
            irq_q        <= |(status_q & irq_en_q);
        end
    end

    assign match_pulse  = match_q;
    assign wrap_pulse   = wrap_q;
    assign reload_pulse = reload_q;
    assign status       = status_q;
    assign irq          = irq_q;
    assign match_cnt    = cnt_q;

endmodule
